// File: rtl/cpu_ctrl.sv
// cpu_ctrl: instruction-sequencing control unit for the 8-bit accumulator CPU.
// Owns the program counter and instruction register, sequences
// IDLE -> FETCH -> EXEC per instruction (free-run or single-step), decodes the
// 3-bit opcode and drives the datapath strobes during EXEC.
module cpu_ctrl (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] ins_i,
    input  logic [1:0] reg_sw_i,
    input  logic       run_i,
    input  logic       step_i,
    output logic [4:0] pc_o,
    output logic [7:0] ir_o,
    output logic [4:0] addr_o,
    output logic [1:0] alu_op_o,
    output logic       wr_o,
    output logic       wm_o,
    output logic       sw_we_o,
    output logic       halted_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10,
        HALT  = 2'b11
    } state_t;

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_JMP = 3'b100;
    localparam logic [2:0] OP_JZ  = 3'b101;
    localparam logic [2:0] OP_JC  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    state_t     state_reg;
    logic [4:0] pc_reg;
    logic [7:0] ir_reg;
    logic       step_q_reg;

    logic [2:0] opcode;
    logic       step_rise;
    logic       jump_taken;
    logic       in_exec;

    assign opcode    = ir_reg[7:5];
    assign in_exec   = (state_reg == EXEC);
    // Only a fresh 0->1 transition of step_i starts an instruction; a held
    // level or an edge that arrived outside IDLE is never remembered.
    assign step_rise = step_i & ~step_q_reg;

    // Branch resolution uses the flags present during this EXEC cycle; an
    // ADD/SUB immediately before has already committed them.
    always_comb begin
        jump_taken = 1'b0;
        case (opcode)
            OP_JMP:  jump_taken = 1'b1;
            OP_JZ:   jump_taken = reg_sw_i[0];
            OP_JC:   jump_taken = reg_sw_i[1];
            default: jump_taken = 1'b0;
        endcase
    end

    // Sequencer: state, program counter, instruction register and step edge history.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg  <= IDLE;
            pc_reg     <= 5'd0;
            ir_reg     <= 8'd0;
            step_q_reg <= 1'b0;
        end else begin
            step_q_reg <= step_i;
            case (state_reg)
                IDLE: begin
                    if (run_i || step_rise) begin
                        state_reg <= FETCH;
                    end
                end
                FETCH: begin
                    // 5-bit increment wraps 31 -> 0 naturally
                    ir_reg    <= ins_i;
                    pc_reg    <= pc_reg + 5'd1;
                    state_reg <= EXEC;
                end
                EXEC: begin
                    if (jump_taken) begin
                        pc_reg <= ir_reg[4:0];
                    end
                    if (opcode == OP_HLT) begin
                        state_reg <= HALT;
                    end else if (run_i) begin
                        state_reg <= FETCH;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                HALT: begin
                    state_reg <= HALT;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Datapath strobe decode, active only in EXEC.
    always_comb begin
        wr_o     = 1'b0;
        wm_o     = 1'b0;
        sw_we_o  = 1'b0;
        alu_op_o = ALU_PASS;
        if (in_exec) begin
            case (opcode)
                OP_LDA: begin
                    wr_o     = 1'b1;
                    alu_op_o = ALU_PASS;
                end
                OP_STA: begin
                    wm_o = 1'b1;
                end
                OP_ADD: begin
                    wr_o     = 1'b1;
                    sw_we_o  = 1'b1;
                    alu_op_o = ALU_ADD;
                end
                OP_SUB: begin
                    wr_o     = 1'b1;
                    sw_we_o  = 1'b1;
                    alu_op_o = ALU_SUB;
                end
                default: begin
                    wr_o     = 1'b0;
                    wm_o     = 1'b0;
                    sw_we_o  = 1'b0;
                    alu_op_o = ALU_PASS;
                end
            endcase
        end
    end

    assign pc_o     = pc_reg;
    assign ir_o     = ir_reg;
    assign addr_o   = ir_reg[4:0];
    assign state_o  = state_reg;
    assign halted_o = (state_reg == HALT);

endmodule

// File: tb/tb_cpu_ctrl.sv
// Testbench for cpu_ctrl: ROM/RAM/accumulator/flag datapath around the DUT,
// an opcode decode table, hand-written corner sequences and random programs
// checked against an instruction-level model of the ISA.
module tb_cpu_ctrl;

    logic       clk_i;
    logic       reset_i;
    logic [7:0] ins_i;
    logic [1:0] reg_sw_i;
    logic       run_i;
    logic       step_i;
    logic [4:0] pc_o;
    logic [7:0] ir_o;
    logic [4:0] addr_o;
    logic [1:0] alu_op_o;
    logic       wr_o;
    logic       wm_o;
    logic       sw_we_o;
    logic       halted_o;
    logic [1:0] state_o;

    cpu_ctrl dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .ins_i    (ins_i),
        .reg_sw_i (reg_sw_i),
        .run_i    (run_i),
        .step_i   (step_i),
        .pc_o     (pc_o),
        .ir_o     (ir_o),
        .addr_o   (addr_o),
        .alu_op_o (alu_op_o),
        .wr_o     (wr_o),
        .wm_o     (wm_o),
        .sw_we_o  (sw_we_o),
        .halted_o (halted_o),
        .state_o  (state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Environment: ROM, RAM, accumulator and flags (C = carry/borrow, Z = zero)
    logic [7:0] rom      [32];
    logic [7:0] init_ram [32];
    logic [7:0] ram      [32];
    logic [7:0] acc;
    logic [1:0] flags;
    logic       force_en;
    logic [1:0] force_flags;
    logic [8:0] alu_res;

    assign ins_i    = rom[pc_o];
    assign reg_sw_i = force_en ? force_flags : flags;

    always_comb begin
        alu_res = {1'b0, ram[addr_o]};
        if (alu_op_o == 2'b01) alu_res = {1'b0, acc} + {1'b0, ram[addr_o]};
        if (alu_op_o == 2'b10) alu_res = {1'b0, acc} - {1'b0, ram[addr_o]};
    end

    always @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            acc   <= 8'd0;
            flags <= 2'b00;
            ram   <= init_ram;
        end else begin
            if (wr_o)    acc <= alu_res[7:0];
            if (wm_o)    ram[addr_o] <= acc;
            if (sw_we_o) flags <= {alu_res[8], (alu_res[7:0] == 8'd0)};
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) begin
            rom[i]      = 8'h00;
            init_ram[i] = 8'h00;
        end
    endtask

    task automatic do_reset();
        reset_i  = 1'b0;
        run_i    = 1'b0;
        step_i   = 1'b0;
        force_en = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
    endtask

    // Expected strobes per opcode: {wr, wm, sw_we, alu_op[1:0]}
    function automatic logic [4:0] exp_strobes(input logic [2:0] op);
        case (op)
            3'd0:    return 5'b1_0_0_00;
            3'd1:    return 5'b0_1_0_00;
            3'd2:    return 5'b1_0_1_01;
            3'd3:    return 5'b1_0_1_10;
            default: return 5'b0_0_0_00;
        endcase
    endfunction

    typedef struct {
        logic [7:0] ins;
        logic [1:0] flg;
        logic       wr;
        logic       wm;
        logic       swe;
        logic [1:0] alu;
        logic [4:0] pc_after;
        logic [1:0] st_after;
    } vec_t;

    vec_t vecs [10];

    // Instruction-level reference model state
    int m_pc, m_acc, m_c, m_z, m_next;
    int m_ram [32];
    int op, a, s, mism, exec_cnt;
    logic [4:0] st;
    logic m_halt;

    initial begin
        clear_mem();
        reset_i = 1'b0; run_i = 1'b0; step_i = 1'b0;
        force_en = 1'b0; force_flags = 2'b00;

        // ---------------- decode table, single-step with forced flags ----------
        vecs[0] = '{8'h05, 2'b00, 1, 0, 0, 2'b00, 5'd1,  2'b00}; // LDA 5
        vecs[1] = '{8'h27, 2'b00, 0, 1, 0, 2'b00, 5'd1,  2'b00}; // STA 7
        vecs[2] = '{8'h43, 2'b00, 1, 0, 1, 2'b01, 5'd1,  2'b00}; // ADD 3
        vecs[3] = '{8'h64, 2'b00, 1, 0, 1, 2'b10, 5'd1,  2'b00}; // SUB 4
        vecs[4] = '{8'h89, 2'b00, 0, 0, 0, 2'b00, 5'd9,  2'b00}; // JMP 9
        vecs[5] = '{8'hA3, 2'b01, 0, 0, 0, 2'b00, 5'd3,  2'b00}; // JZ 3, Z=1
        vecs[6] = '{8'hA3, 2'b10, 0, 0, 0, 2'b00, 5'd1,  2'b00}; // JZ 3, Z=0
        vecs[7] = '{8'hD1, 2'b10, 0, 0, 0, 2'b00, 5'd17, 2'b00}; // JC 17, C=1
        vecs[8] = '{8'hD1, 2'b01, 0, 0, 0, 2'b00, 5'd1,  2'b00}; // JC 17, C=0
        vecs[9] = '{8'hE0, 2'b11, 0, 0, 0, 2'b00, 5'd1,  2'b11}; // HLT
        for (int i = 0; i < 10; i++) begin
            clear_mem();
            rom[0] = vecs[i].ins;
            do_reset();
            chk("reset_state", state_o, 2'b00);
            force_en = 1'b1;
            force_flags = vecs[i].flg;
            step_i = 1'b1;
            tick();
            step_i = 1'b0;
            chk("tbl_fetch_state", state_o, 2'b01);
            tick();
            chk("tbl_exec_state", state_o, 2'b10);
            chk("tbl_strobes", {wr_o, wm_o, sw_we_o, alu_op_o},
                {vecs[i].wr, vecs[i].wm, vecs[i].swe, vecs[i].alu});
            chk("tbl_addr", addr_o, vecs[i].ins[4:0]);
            tick();
            chk("tbl_pc_after", pc_o, vecs[i].pc_after);
            chk("tbl_state_after", state_o, vecs[i].st_after);
            chk("tbl_halted", halted_o, (vecs[i].st_after == 2'b11));
        end

        // ---------------- example program, free-run ----------------
        clear_mem();
        rom[0] = 8'h0A; rom[1] = 8'h4B; rom[2] = 8'h2C; rom[3] = 8'hE0;
        init_ram[10] = 8'h05; init_ram[11] = 8'h03;
        do_reset();
        run_i = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            $display("cycle %0d: state=%0d pc=%0d wr=%0b wm=%0b alu=%0d halted=%0b",
                     cyc, state_o, pc_o, wr_o, wm_o, alu_op_o, halted_o);
            chk("prog_wr", wr_o, (cyc == 2 || cyc == 4));
            chk("prog_wm", wm_o, (cyc == 6));
            chk("prog_alu", alu_op_o, (cyc == 4) ? 2'b01 : 2'b00);
            chk("prog_halted", halted_o, (cyc >= 9));
            if (cyc >= 9) chk("prog_pc_hold", pc_o, 5'd4);
        end
        chk("prog_ram12", ram[12], 8'h08);

        // ---------------- asynchronous reset mid-EXEC of ADD ----------------
        do_reset();
        run_i = 1'b1;
        tick(); tick(); tick(); tick();
        chk("rst_pre_add_wr", wr_o, 1'b1);
        reset_i = 1'b0;
        #1;
        chk("rst_async", {pc_o, ir_o, wr_o, wm_o, sw_we_o, alu_op_o, state_o, halted_o}, 0);
        @(negedge clk_i);
        reset_i = 1'b1;

        // ---------------- branches ----------------
        clear_mem();
        for (int i = 0; i < 4; i++) rom[i] = 8'h0A;
        rom[4] = 8'h6A; rom[5] = 8'hBE;
        init_ram[10] = 8'h42; init_ram[11] = 8'h40;
        do_reset();
        run_i = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        chk("jz_taken_pc", pc_o, 5'h1E);
        rom[4] = 8'h6B;
        do_reset();
        run_i = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        chk("jz_not_taken_pc", pc_o, 5'd6);

        clear_mem();
        rom[0] = 8'h0A; rom[1] = 8'h4B; rom[2] = 8'hC2;
        init_ram[10] = 8'hFF; init_ram[11] = 8'h01;
        do_reset();
        run_i = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("jc_taken_pc", pc_o, 5'd2);

        // ---------------- PC wrap ----------------
        clear_mem();
        rom[0] = 8'h9F; rom[31] = 8'h01;
        do_reset();
        run_i = 1'b1;
        tick(); tick(); tick();
        chk("wrap_pc_31", pc_o, 5'd31);
        tick();
        chk("wrap_pc_0", pc_o, 5'd0);
        chk("wrap_ir", ir_o, 8'h01);

        // ---------------- single-step: held step, pulse in EXEC ----------------
        clear_mem();
        do_reset();
        exec_cnt = 0;
        step_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (state_o == 2'b10) exec_cnt++;
        end
        step_i = 1'b0;
        tick();
        chk("step_hold_execs", exec_cnt, 1);
        chk("step_hold_state", state_o, 2'b00);
        chk("step_hold_pc", pc_o, 5'd1);
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
        tick();
        chk("step2_exec", state_o, 2'b10);
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
        tick(); tick();
        chk("step_exec_pulse_state", state_o, 2'b00);
        chk("step_exec_pulse_pc", pc_o, 5'd2);

        // ---------------- run drop during FETCH of STA ----------------
        clear_mem();
        rom[0] = 8'h0A; rom[1] = 8'h2C; rom[2] = 8'h0A;
        do_reset();
        run_i = 1'b1;
        tick(); tick(); tick();
        chk("drop_fetch_sta", state_o, 2'b01);
        run_i = 1'b0;
        tick();
        chk("drop_wm", wm_o, 1'b1);
        tick();
        chk("drop_idle", state_o, 2'b00);
        chk("drop_pc", pc_o, 5'd2);
        tick(); tick();
        chk("drop_idle_hold", state_o, 2'b00);
        chk("drop_pc_hold", pc_o, 5'd2);

        // ---------------- random programs vs ISA model ----------------
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 32; i++) begin
                rom[i] = 8'($urandom_range(0, 255));
                init_ram[i] = 8'($urandom_range(0, 255));
                m_ram[i] = int'(init_ram[i]);
            end
            m_pc = 0; m_acc = 0; m_c = 0; m_z = 0; m_halt = 1'b0;
            do_reset();
            run_i = 1'b1;
            for (int n = 0; n < 40 && !m_halt; n++) begin
                op = int'(rom[m_pc][7:5]);
                a  = int'(rom[m_pc][4:0]);
                tick();
                chk("rnd_fetch_state", state_o, 2'b01);
                chk("rnd_fetch_pc", pc_o, m_pc);
                tick();
                st = exp_strobes(3'(op));
                chk("rnd_exec_state", state_o, 2'b10);
                chk("rnd_ir", ir_o, rom[m_pc]);
                chk("rnd_exec_pc", pc_o, (m_pc + 1) % 32);
                chk("rnd_strobes", {wr_o, wm_o, sw_we_o, alu_op_o}, st);
                m_next = (m_pc + 1) % 32;
                case (op)
                    0: m_acc = m_ram[a];
                    1: m_ram[a] = m_acc;
                    2: begin
                        s = m_acc + m_ram[a];
                        m_c = (s > 255) ? 1 : 0;
                        m_acc = s % 256;
                        m_z = (m_acc == 0) ? 1 : 0;
                    end
                    3: begin
                        m_c = (m_acc < m_ram[a]) ? 1 : 0;
                        m_acc = (m_acc - m_ram[a] + 256) % 256;
                        m_z = (m_acc == 0) ? 1 : 0;
                    end
                    4: m_next = a;
                    5: if (m_z == 1) m_next = a;
                    6: if (m_c == 1) m_next = a;
                    default: m_halt = 1'b1;
                endcase
                m_pc = m_next;
            end
            tick();
            if (m_halt) begin
                chk("rnd_halted", halted_o, 1'b1);
                chk("rnd_halt_state", state_o, 2'b11);
                chk("rnd_halt_pc", pc_o, m_pc);
            end else begin
                chk("rnd_next_pc", pc_o, m_pc);
            end
            mism = 0;
            for (int i = 0; i < 32; i++) if (int'(ram[i]) != m_ram[i]) mism++;
            chk("rnd_ram_mismatches", mism, 0);
            chk("rnd_acc", acc, m_acc);
            $display("random program %0d: halted=%0b pc=%0d acc=%0h", p, m_halt, m_pc, m_acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
